// File: rtl/fft_pkg.sv
// Shared constants for the FFT front end: default sample geometry and the
// deinterleaver state encoding.
package fft_pkg;

    localparam int FFT_WORDSIZE   = 16;
    localparam int FFT_NUMSAMPLES = 32;
    localparam int FFT_IDX_W      = $clog2(FFT_NUMSAMPLES);
    localparam int FFT_BEAT_W     = FFT_IDX_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/bit_reverse.sv
// Combinational index reverser: bit i of the result is bit WIDTH-1-i of idx.
module bit_reverse #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] idx,
    output logic [WIDTH-1:0] rev
);

    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = idx[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/sample_deinterleaver.sv
// Gathers four-sample beats (b, b+Q, b+2Q, b+3Q) into a frame buffer and
// streams the frame out one sample per cycle in natural or bit-reversed order.
module sample_deinterleaver
    import fft_pkg::*;
#(
    parameter int WORDSIZE   = FFT_WORDSIZE,
    parameter int NUMSAMPLES = FFT_NUMSAMPLES,
    parameter bit BITREV     = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [WORDSIZE-1:0]           in_word0,
    input  logic [WORDSIZE-1:0]           in_word1,
    input  logic [WORDSIZE-1:0]           in_word2,
    input  logic [WORDSIZE-1:0]           in_word3,
    input  logic                          in_error,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [WORDSIZE-1:0]           out_data,
    output logic [$clog2(NUMSAMPLES)-1:0] out_index,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int IDX_W  = $clog2(NUMSAMPLES);
    localparam int BEAT_W = IDX_W - 2;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat, beat_nxt;
    logic [IDX_W-1:0]    k, k_nxt;
    logic [IDX_W-1:0]    k_rev;
    logic [IDX_W-1:0]    rd_addr;
    logic                wr_en;
    logic [WORDSIZE-1:0] mem [NUMSAMPLES];

    // Q is a power of two, so b + j*Q is just j prepended to b.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{2'd0, beat}] <= in_word0;
            mem[{2'd1, beat}] <= in_word1;
            mem[{2'd2, beat}] <= in_word2;
            mem[{2'd3, beat}] <= in_word3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            beat  <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        k_nxt     = k;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FILL;
                    beat_nxt  = '0;
                    k_nxt     = '0;
                end
            end
            ST_FILL: begin
                // An error beat is dropped even if in_valid is also high.
                if (in_error) begin
                    state_nxt = ST_ERR;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (beat == BEAT_W'(NUMSAMPLES / 4 - 1)) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (k == IDX_W'(NUMSAMPLES - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (!start) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    bit_reverse #(
        .WIDTH(IDX_W)
    ) u_bit_reverse (
        .idx(k),
        .rev(k_rev)
    );

    assign rd_addr   = BITREV ? k_rev : k;
    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? mem[rd_addr] : '0;
    assign out_index = out_valid ? k : '0;
    assign busy      = (state == ST_FILL) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);

endmodule

// File: doc/sample_deinterleaver.md
# sample_deinterleaver

Collects the four-words-per-cycle sample stream produced by the input reader (beat b carries samples b, b+8, b+16, b+24) into a local 32-entry buffer. It then streams the samples out one per cycle, in natural or bit-reversed order, under a valid/ready handshake. It sits directly downstream of the input reader and feeds the first FFT stage, which consumes single-word samples.

## Interface
- WORDSIZE, 16, bits per sample
- NUMSAMPLES, 32, samples per frame; power of two, multiple of 4
- BITREV, 0, 0 = natural output order, 1 = bit-reversed output order
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; rising into FILL from IDLE, must drop to leave DONE/ERR
- in_valid  input  1  in_word0..3 carry one beat this cycle
- in_word0  input  WORDSIZE  sample b
- in_word1  input  WORDSIZE  sample b+NUMSAMPLES/4
- in_word2  input  WORDSIZE  sample b+NUMSAMPLES/2
- in_word3  input  WORDSIZE  sample b+3*NUMSAMPLES/4
- in_error  input  1  upstream read error
- out_ready  input  1  downstream accepts out_data this cycle
- out_valid  output  1  out_data/out_index valid
- out_data  output  WORDSIZE  sample value; 0 when out_valid=0
- out_index  output  log2(NUMSAMPLES)  output sequence number k
- busy  output  1  state is FILL or DRAIN
- done  output  1  frame fully drained
- error  output  1  frame aborted by in_error

## Operation
- States: IDLE, FILL, DRAIN, DONE, ERR.
- IDLE: start=1 -> FILL; beat counter b=0, output counter k=0.
- FILL: in_valid=1 writes mem[b], mem[b+Q], mem[b+2Q], mem[b+3Q] (Q=NUMSAMPLES/4), then b++. in_valid=0 stalls; no write. After beat Q-1 is accepted -> DRAIN.
- FILL with in_error=1 -> ERR; the beat in that cycle is discarded and takes priority over in_valid.
- DRAIN: out_valid=1, out_index=k, out_data=mem[addr(k)], where addr(k)=k (BITREV=0) or the bit reversal of k over log2(NUMSAMPLES) bits (BITREV=1). On out_valid&out_ready, k++. After k=NUMSAMPLES-1 is accepted -> DONE.
- DONE: done=1; start=0 -> IDLE (done clears).
- ERR: error=1; start=0 -> IDLE (error clears).
- in_valid and in_error are ignored outside FILL. start toggles during FILL/DRAIN are ignored.
- Counters are exact-width and never wrap mid-frame; both are reset to 0 on IDLE->FILL.
- Memory is not reset; its contents are only observable in DRAIN, after a complete FILL.

## Timing
- Reset (async, immediate): state=IDLE, b=0, k=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0, error=0.
- rst_n asserted mid-FILL/DRAIN aborts the frame; partial data is discarded.
- start sampled at cycle T: FILL from T+1; the first beat can be written at T+1.
- Last beat accepted at cycle T: out_valid=1 at T+1, with sample addr(0) on out_data in the same cycle (combinational read of the register array).
- out_data/out_index held stable while out_valid=1 and out_ready=0.
- Full-throughput frame: 1 cycle IDLE->FILL, Q fill cycles, NUMSAMPLES drain cycles; done=1 the cycle after the last transfer.

## Structure
- Shared package fft_pkg: WORDSIZE, NUMSAMPLES, state encoding constants, index width localparams.
- Sub-module bit_reverse: parameterised combinational index reverser, used when BITREV=1.
- Memory: register array NUMSAMPLES x WORDSIZE, 4 write ports (one per word), 1 read port.

## Test plan
- Ramp, BITREV=0: beats b=0..7 on consecutive cycles with words (b, b+8, b+16, b+24), out_ready=1 -> out_data 0..31 on 32 consecutive cycles, out_index=out_data, done=1 the next cycle.
- Same stimulus, BITREV=1 -> out_data sequence 0,16,8,24,4,20,12,28,...,15,31; out_index 0..31.
- in_valid only on alternate cycles -> identical output to the ramp test; out_valid rises exactly 1 cycle after the 8th beat.
- out_ready toggling 1,0,1,0 during DRAIN -> out_data stable across stall cycles, exactly 32 transfers, no duplicates or skips.
- in_error=1 at beat 3 -> error=1 next cycle, out_valid never asserted; start=0 -> IDLE with error=0; a following clean frame drains correctly.
- rst_n low during DRAIN at k=10 -> all outputs at reset values with no clock edge; a subsequent full frame yields the complete 0..31 sequence.
